sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 126 ++++++++++++
 tb/tb_sram_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Wait-state SRAM controller: freezes the pipeline for WAIT_CYCLES+1 cycles per access.
// Optional one-entry read buffer is compiled in with `define SRAM_CTRL_RDBUF_EN.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic            rd_en,
  input  logic [31:0]     address,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            ready,
  output logic            SRAM_WE_N,
  output logic [16:0]     SRAM_ADDR,
  inout  wire logic [31:0] SRAM_DQ
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [16:0] word_addr;
  logic        req;
  logic        hit;
  logic        accept;
  logic        drive;

`ifdef SRAM_CTRL_RDBUF_EN
  logic        buf_valid;
  logic [31:0] buf_tag;
  logic [31:0] buf_data;
  logic [31:0] addr_q;
`endif

  always_comb begin
    word_addr = 17'((address - 32'(BASE_ADDR)) >> 2);
    req       = wr_en | rd_en;
`ifdef SRAM_CTRL_RDBUF_EN
    hit       = (state == IDLE) && rd_en && !wr_en && buf_valid && (buf_tag == address);
    rdata     = hit ? buf_data : rdata_q;
`else
    hit       = 1'b0;
    rdata     = rdata_q;
`endif
    accept    = (state == IDLE) && req && !hit;
    ready     = ((state == IDLE) && !(req && !hit)) || (state == DONE);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = ACCESS;
          cnt_nxt   = 4'(WAIT_CYCLES - 1);
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Address and write data are latched at acceptance so the requester may drop them mid-access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      SRAM_ADDR <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        SRAM_ADDR <= word_addr;
        write_q   <= wr_en;
        wdata_q   <= wdata;
      end
      if ((state == ACCESS) && (cnt == 4'd0) && !write_q)
        rdata_q <= SRAM_DQ;
    end
  end

`ifdef SRAM_CTRL_RDBUF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
      addr_q    <= '0;
    end else begin
      if (accept)
        addr_q <= address;
      if ((state == DONE) && !write_q) begin
        buf_valid <= 1'b1;
        buf_tag   <= addr_q;
        buf_data  <= rdata_q;
      end else if (accept && wr_en && buf_valid && (buf_tag == address)) begin
        buf_data  <= wdata;
      end
    end
  end
`endif

  assign drive     = (state == ACCESS) && write_q;
  assign SRAM_WE_N = !drive;
  assign SRAM_DQ   = drive ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: behavioural SRAM plus a transaction-level reference model.
module tb_sram_controller;

  localparam int unsigned W    = 5;
  localparam int unsigned BASE = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, rd_en;
  logic [31:0] address, wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        SRAM_WE_N;
  logic [16:0] SRAM_ADDR;
  wire  [31:0] SRAM_DQ;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] sram_mem [0:131071];
  logic [31:0] ref_wr [int unsigned];
  logic [16:0] m_addr;
  logic [31:0] m_last;
  logic        m_buf_valid;
  logic [31:0] m_buf_tag;
  logic [31:0] m_buf_data;

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(input int unsigned idx);
    return 32'h5A00_0000 ^ (idx * 32'h9E37_79B1);
  endfunction

  function automatic int unsigned word_of(input logic [31:0] a);
    int unsigned off;
    off = a - BASE;
    return (off / 4) % 131072;
  endfunction

  function automatic logic [31:0] ref_read(input int unsigned idx);
    return ref_wr.exists(idx) ? ref_wr[idx] : pattern(idx);
  endfunction

  // SRAM model: drives the bus whenever the controller is not writing
  assign SRAM_DQ = SRAM_WE_N ? sram_mem[SRAM_ADDR] : 'z;

  initial begin
    for (int i = 0; i < 131072; i++) sram_mem[i] = pattern(i);
    forever begin
      @(posedge clk);
      if (!SRAM_WE_N) sram_mem[SRAM_ADDR] <= SRAM_DQ;
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_xfer(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wd);
    int unsigned lat, widx;
    logic        hit, in_acc, exp_ready, exp_we_n;
    logic [16:0] exp_addr;
    logic [31:0] exp_dq, exp_rd;
    hit = 1'b0;
`ifdef SRAM_CTRL_RDBUF_EN
    hit = re && !we && m_buf_valid && (m_buf_tag == addr);
`endif
    lat  = hit ? 0 : W + 1;
    widx = word_of(addr);
    if (we)       exp_rd = m_last;
    else if (hit) exp_rd = m_buf_data;
    else          exp_rd = ref_read(widx);
    @(posedge clk); #1;
    wr_en = we; rd_en = re; address = addr; wdata = wd;
    for (int c = 0; c <= int'(lat); c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      in_acc    = !hit && (c >= 1) && (c <= int'(W));
      exp_ready = (c == int'(lat));
      exp_we_n  = !(in_acc && we);
      exp_addr  = (!hit && c >= 1) ? 17'(widx) : m_addr;
      exp_dq    = exp_we_n ? sram_mem[exp_addr] : wd;
      n_cmp++;
      if (ready !== exp_ready) begin
        n_bad++; $display("FAIL ready a=%0d c=%0d got %b want %b", addr, c, ready, exp_ready);
      end
      n_cmp++;
      if (SRAM_WE_N !== exp_we_n) begin
        n_bad++; $display("FAIL we_n a=%0d c=%0d got %b want %b", addr, c, SRAM_WE_N, exp_we_n);
      end
      n_cmp++;
      if (SRAM_ADDR !== exp_addr) begin
        n_bad++; $display("FAIL sram_addr a=%0d c=%0d got %h want %h", addr, c, SRAM_ADDR, exp_addr);
      end
      n_cmp++;
      if (SRAM_DQ !== exp_dq) begin
        n_bad++; $display("FAIL dq a=%0d c=%0d got %h want %h", addr, c, SRAM_DQ, exp_dq);
      end
      if (c == int'(lat)) begin
        n_cmp++;
        if (rdata !== exp_rd) begin
          n_bad++; $display("FAIL rdata a=%0d got %h want %h", addr, rdata, exp_rd);
        end
      end
    end
    if (!hit) m_addr = 17'(widx);
    if (we) begin
      ref_wr[widx] = wd;
      if (m_buf_valid && m_buf_tag == addr) m_buf_data = wd;
    end else if (!hit) begin
      m_last      = exp_rd;
      m_buf_valid = 1'b1;
      m_buf_tag   = addr;
      m_buf_data  = exp_rd;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; wdata = '0;
    m_addr = '0; m_last = '0; m_buf_valid = 1'b0; m_buf_tag = '0; m_buf_data = '0;
    #3;
    n_cmp++; if (ready !== 1'b1)     begin n_bad++; $display("FAIL rst_ready got %b want 1", ready); end
    n_cmp++; if (SRAM_WE_N !== 1'b1) begin n_bad++; $display("FAIL rst_we_n got %b want 1", SRAM_WE_N); end
    n_cmp++; if (SRAM_ADDR !== '0)   begin n_bad++; $display("FAIL rst_addr got %h want 0", SRAM_ADDR); end
    n_cmp++; if (rdata !== '0)       begin n_bad++; $display("FAIL rst_rdata got %h want 0", rdata); end
    rd_en = 1'b1; #1;
    n_cmp++; if (ready !== 1'b0)     begin n_bad++; $display("FAIL rst_ready_req got %b want 0", ready); end
    rd_en = 1'b0;
    @(negedge clk); @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_write_read();
    do_xfer(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF); idle();
    do_xfer(1'b0, 1'b1, 32'd1028, $urandom);       idle();
  endtask

  task automatic test_both_enables();
    do_xfer(1'b1, 1'b1, 32'd1032, 32'h1234_5678); idle();
    do_xfer(1'b0, 1'b1, 32'd1032, '0);             idle();
  endtask

  task automatic test_wrap();
    do_xfer(1'b0, 1'b1, 32'd0, '0);      idle();
    do_xfer(1'b1, 1'b0, 32'd0, $urandom); idle();
    do_xfer(1'b0, 1'b1, 32'd0, '0);      idle();
  endtask

  task automatic test_back_to_back();
    do_xfer(1'b1, 1'b0, 32'd1044, $urandom);
    do_xfer(1'b0, 1'b1, 32'd1044, '0);
    do_xfer(1'b0, 1'b1, 32'd1048, '0);
    idle();
  endtask

  task automatic test_random();
    int unsigned op;
    logic [31:0] a;
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 2);
      a  = BASE + 4 * $urandom_range(0, 7);
      do_xfer(op != 1, op != 0, a, $urandom);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();
  endtask

  task automatic test_rdbuf();
    do_xfer(1'b0, 1'b1, 32'd1036, '0);
    do_xfer(1'b0, 1'b1, 32'd1036, '0);
    idle();
    do_xfer(1'b1, 1'b0, 32'd1036, $urandom); idle();
    do_xfer(1'b0, 1'b1, 32'd1036, '0);       idle();
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] wd;
    wd = $urandom;
    @(posedge clk); #1;
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1040; wdata = wd;
    repeat (3) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (SRAM_WE_N !== 1'b1) begin n_bad++; $display("FAIL midrst_we_n got %b want 1", SRAM_WE_N); end
    n_cmp++; if (SRAM_DQ !== sram_mem[0]) begin n_bad++; $display("FAIL midrst_dq got %h want %h", SRAM_DQ, sram_mem[0]); end
    n_cmp++; if (SRAM_ADDR !== '0)   begin n_bad++; $display("FAIL midrst_addr got %h want 0", SRAM_ADDR); end
    n_cmp++; if (rdata !== '0)       begin n_bad++; $display("FAIL midrst_rdata got %h want 0", rdata); end
    wr_en = 1'b0; #1;
    n_cmp++; if (ready !== 1'b1)     begin n_bad++; $display("FAIL midrst_ready got %b want 1", ready); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (ready !== 1'b1)     begin n_bad++; $display("FAIL postrst_ready got %b want 1", ready); end
    ref_wr[word_of(32'd1040)] = wd;
    m_addr = '0; m_last = '0; m_buf_valid = 1'b0;
    do_xfer(1'b0, 1'b1, 32'd1040, '0); idle();
    do_xfer(1'b0, 1'b1, 32'd1028, '0); idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_both_enables();
    test_wrap();
    test_back_to_back();
    test_rdbuf();
    test_random();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
